// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, key-schedule shift counts and
// the key-schedule state type. Also used by the expansion/IP/P stages.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 28;
  localparam int CD_W       = 2 * HALF_W;
  localparam int KEY_W      = 64;
  localparam int SUBKEY_W   = 48;

  typedef enum logic {IDLE, RUN} state_t;

  // Entries are 1-based DES bit numbers; output bit 1 is the first entry.
  localparam int PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TABLE [NUM_ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // DES bit n of a 64-bit key lives at key[64-n]; parity bits fall out here.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] res;
    res = '0;
    for (int i = 0; i < CD_W; i++) begin
      res[CD_W-1-i] = key[KEY_W-PC1_TABLE[i]];
    end
    return res;
  endfunction

  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input int amt, input logic left);
    logic [HALF_W-1:0] res;
    if (left) begin
      res = (amt == 2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
    end else begin
      res = (amt == 2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
    end
    return res;
  endfunction

  function automatic logic [CD_W-1:0] rotate_cd(input logic [CD_W-1:0] cd,
                                                input int amt, input logic left);
    return {rot28(cd[CD_W-1:HALF_W], amt, left), rot28(cd[HALF_W-1:0], amt, left)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure bit selection from the 56-bit C||D register to a
// 48-bit round subkey (DES bit 1 is the MSB on both sides).
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  generate
    for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
      assign subkey[SUBKEY_W-1-gi] = cd[CD_W-PC2_TABLE[gi]];
    end
  endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: accepts a key, then streams the 16 subkeys
// (forward for encrypt, reversed for decrypt) one per consumer handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int SUBKEY_W   = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy
);

  generate
    if (NUM_ROUNDS != des_pkg::NUM_ROUNDS || SUBKEY_W != des_pkg::SUBKEY_W) begin : g_bad_param
      $error("des_key_schedule: NUM_ROUNDS must be 16 and SUBKEY_W must be 48");
    end
  endgenerate

  state_t      state_reg;
  logic [55:0] cd_reg;
  logic [3:0]  round_idx_reg;
  logic        dir_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cd_reg        <= '0;
      round_idx_reg <= '0;
      dir_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (key_valid) begin
            dir_reg       <= decrypt;
            // Decrypt starts from the unrotated PC-1: total rotation is 28,
            // so that already equals the last encrypt round's C||D.
            cd_reg        <= decrypt ? pc1(key_in)
                                     : rotate_cd(pc1(key_in), SHIFT_TABLE[0], 1'b1);
            round_idx_reg <= '0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (round_idx_reg == 4'd15) begin
              round_idx_reg <= '0;
              state_reg     <= IDLE;
            end else begin
              round_idx_reg <= round_idx_reg + 4'd1;
              cd_reg <= dir_reg
                ? rotate_cd(cd_reg, SHIFT_TABLE[4'd15 - round_idx_reg], 1'b0)
                : rotate_cd(cd_reg, SHIFT_TABLE[round_idx_reg + 4'd1], 1'b1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_reg),
    .subkey (subkey)
  );

  assign round_idx    = round_idx_reg;
  assign subkey_valid = (state_reg == RUN);
  assign busy         = (state_reg == RUN);
  assign key_ready    = (state_reg == IDLE) && !rst;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1
// worked example, degenerate keys, stalls, mid-stream reset and ignored keys.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  localparam logic [47:0] K_ENC [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  logic [47:0] exp_q [16];

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input bit reversed, input logic [47:0] fill, input bit use_fill);
    for (int i = 0; i < 16; i++) begin
      if (use_fill) exp_q[i] = fill;
      else          exp_q[i] = reversed ? K_ENC[15-i] : K_ENC[i];
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic accept_key(input logic [63:0] k, input bit dec);
    int n;
    key_in = k; decrypt = dec; key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("key_ready_wait", {63'd0, key_ready}, 64'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    $display("[TB] key %h decrypt=%0d accepted", k, dec);
  endtask

  task automatic collect(input string name, input bit stall);
    int r;
    int cyc;
    bit rdy;
    r = 0; cyc = 0;
    while (r < 16 && cyc < 300) begin
      chk({name, "_valid"}, {63'd0, subkey_valid}, 64'd1);
      chk({name, "_idx"}, {60'd0, round_idx}, 64'(r));
      chk({name, "_subkey"}, {16'd0, subkey}, {16'd0, exp_q[r]});
      rdy = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      subkey_ready = rdy;
      @(posedge clk); #1;
      if (rdy) r++;
      cyc++;
    end
    chk({name, "_cycle_budget"}, 64'(r), 64'd16);
    if (!stall) chk({name, "_cycles"}, 64'(cyc), 64'd16);
    chk({name, "_end_valid"}, {63'd0, subkey_valid}, 64'd0);
    chk({name, "_end_ready"}, {63'd0, key_ready}, 64'd1);
    subkey_ready = 1'b1;
    $display("[TB] stream %s done after %0d cycles", name, cyc);
  endtask

  initial begin
    rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_key_ready", {63'd0, key_ready}, 64'd0);
    chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_subkey", {16'd0, subkey}, 64'd0);
    chk("rst_idx", {60'd0, round_idx}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_key_ready", {63'd0, key_ready}, 64'd1);
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_no_effect", {63'd0, subkey_valid}, 64'd0);
    $display("[TB] reset checks done");

    set_exp(1'b0, '0, 1'b0);
    accept_key(KEY_A, 1'b0);
    collect("enc", 1'b0);

    set_exp(1'b1, '0, 1'b0);
    accept_key(KEY_A, 1'b1);
    collect("dec", 1'b0);

    set_exp(1'b0, 48'h0, 1'b1);
    accept_key(64'h0000000000000000, 1'b0);
    collect("zero", 1'b0);
    accept_key(64'h0101010101010101, 1'b0);
    collect("parity_only", 1'b0);
    set_exp(1'b0, 48'hFFFFFFFFFFFF, 1'b1);
    accept_key(64'hFFFFFFFFFFFFFFFF, 1'b1);
    collect("ones", 1'b0);

    set_exp(1'b0, '0, 1'b0);
    accept_key(KEY_A, 1'b0);
    collect("stall", 1'b1);

    // Abort the stream at round 7 with a reset pulse.
    accept_key(KEY_A, 1'b0);
    subkey_ready = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    chk("abort_idx", {60'd0, round_idx}, 64'd7);
    chk("abort_subkey", {16'd0, subkey}, {16'd0, K_ENC[7]});
    subkey_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_valid", {63'd0, subkey_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_key_ready", {63'd0, key_ready}, 64'd1);
    $display("[TB] reset at round 7 aborted stream");
    subkey_ready = 1'b1;
    set_exp(1'b1, '0, 1'b0);
    accept_key(KEY_A, 1'b1);
    collect("after_abort", 1'b0);

    // A second key held valid during RUN must wait for the next IDLE cycle.
    set_exp(1'b0, '0, 1'b0);
    accept_key(KEY_A, 1'b0);
    key_in = 64'hFFFFFFFFFFFFFFFF; decrypt = 1'b1; key_valid = 1'b1;
    collect("held_key", 1'b0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    set_exp(1'b0, 48'hFFFFFFFFFFFF, 1'b1);
    collect("second_key", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
